// File: rtl/my_mul_if.sv
// Request/response bundle shared between the execution unit and the
// sequential multiplier. Operands and the run_in toggle flow toward the
// multiplier; the product, overflow flag and run_out toggle flow back.
interface my_mul_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               signed_mul;
    logic               byte_mode;
    logic               run_in;
    logic [2*WIDTH-1:0] p;
    logic               ovf;
    logic               run_out;

    modport master (
        output a, b, signed_mul, byte_mode, run_in,
        input  p, ovf, run_out
    );

    modport slave (
        input  a, b, signed_mul, byte_mode, run_in,
        output p, ovf, run_out
    );
endinterface

// File: rtl/my_mul.sv
// Iterative shift-add multiplier (MUL/IMUL, word and byte forms).
// Signed operands are reduced to magnitudes at capture time, the magnitudes
// are multiplied one multiplier bit per clock, and the sign is reapplied on
// the final edge. Handshake: the block is busy whenever run_in != run_out and
// flips run_out when the product is written.
module my_mul #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     reset,
    my_mul_if.slave  bus
);
    localparam int HALF = WIDTH / 2;
    localparam int PW   = $clog2(WIDTH + 1);

    // Magnitude of an operand in the selected form. In byte mode only the low
    // half participates and the result is zero-extended. The most-negative
    // value negates to itself, which is still the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                             input logic s,
                                             input logic bm);
        logic [HALF-1:0] low;
        logic [WIDTH-1:0] res;
        low = v[HALF-1:0];
        if (bm) begin
            if (s && low[HALF-1]) begin
                low = {HALF{1'b0}} - low;
            end else begin
                low = v[HALF-1:0];
            end
            res = {{(WIDTH-HALF){1'b0}}, low};
        end else begin
            if (s && v[WIDTH-1]) begin
                res = {WIDTH{1'b0}} - v;
            end else begin
                res = v;
            end
        end
        return res;
    endfunction

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [PW-1:0]      r_phase;
    logic               r_neg;
    logic               r_signed;
    logic               r_byte;
    logic [2*WIDTH-1:0] r_p;
    logic               r_ovf;
    logic               r_run_out;

    logic               w_busy;
    logic [PW-1:0]      w_n;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_final;
    logic               w_ovf;

    assign w_busy   = (bus.run_in != r_run_out);
    assign w_n      = r_byte ? PW'(HALF) : PW'(WIDTH);
    assign w_sign_a = bus.byte_mode ? bus.a[HALF-1] : bus.a[WIDTH-1];
    assign w_sign_b = bus.byte_mode ? bus.b[HALF-1] : bus.b[WIDTH-1];

    // Apply the result sign, confine byte results to the low word, derive ovf.
    always_comb begin
        w_prod  = r_acc;
        w_final = r_acc;
        w_ovf   = 1'b0;
        if (r_signed && r_neg) begin
            w_prod = {(2*WIDTH){1'b0}} - r_acc;
        end else begin
            w_prod = r_acc;
        end
        if (r_byte) begin
            w_final = {{WIDTH{1'b0}}, w_prod[WIDTH-1:0]};
        end else begin
            w_final = w_prod;
        end
        case ({r_byte, r_signed})
            2'b00:   w_ovf = (w_final[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
            2'b01:   w_ovf = (w_final[2*WIDTH-1:WIDTH] != {WIDTH{w_final[WIDTH-1]}});
            2'b10:   w_ovf = (w_final[WIDTH-1:HALF] != {(WIDTH-HALF){1'b0}});
            2'b11:   w_ovf = (w_final[WIDTH-1:HALF] != {(WIDTH-HALF){w_final[HALF-1]}});
            default: w_ovf = 1'b0;
        endcase
    end

    // Idle: capture operands. Busy: one shift-add step per edge, then write
    // the product and flip run_out on the edge after the last step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand   <= {(2*WIDTH){1'b0}};
            r_mplier  <= {WIDTH{1'b0}};
            r_acc     <= {(2*WIDTH){1'b0}};
            r_phase   <= {PW{1'b0}};
            r_neg     <= 1'b0;
            r_signed  <= 1'b0;
            r_byte    <= 1'b0;
            r_p       <= {(2*WIDTH){1'b0}};
            r_ovf     <= 1'b0;
            r_run_out <= 1'b0;
        end else if (!w_busy) begin
            r_mcand  <= {{WIDTH{1'b0}}, mag(bus.a, bus.signed_mul, bus.byte_mode)};
            r_mplier <= mag(bus.b, bus.signed_mul, bus.byte_mode);
            r_neg    <= w_sign_a ^ w_sign_b;
            r_signed <= bus.signed_mul;
            r_byte   <= bus.byte_mode;
            r_acc    <= {(2*WIDTH){1'b0}};
            r_phase  <= {PW{1'b0}};
        end else if (r_phase == w_n) begin
            r_p       <= w_final;
            r_ovf     <= w_ovf;
            r_run_out <= ~r_run_out;
            r_phase   <= {PW{1'b0}};
        end else begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end else begin
                r_acc <= r_acc;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_phase  <= r_phase + PW'(1);
        end
    end

    assign bus.p       = r_p;
    assign bus.ovf     = r_ovf;
    assign bus.run_out = r_run_out;
endmodule

// File: tb/tb_my_mul.sv
// Directed bench for my_mul: a reference model computes each product with
// wide signed integer arithmetic; expectations are queued when an operation
// is launched and popped when run_out flips.
module tb_my_mul;
    logic clk;
    logic reset;

    my_mul_if #(.WIDTH(16)) ifc ();

    my_mul #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] p;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: true integer product, range test for ovf.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic s, input logic bm,
                                  output logic [31:0] p, output logic ovf);
        longint x, y, prod;
        if (bm) begin
            x = longint'(a[7:0]);
            y = longint'(b[7:0]);
            if (s && a[7]) x = x - 256;
            if (s && b[7]) y = y - 256;
            prod = x * y;
            p    = {16'h0000, prod[15:0]};
            ovf  = s ? (prod < -128 || prod > 127) : (prod > 255);
        end else begin
            x = longint'(a);
            y = longint'(b);
            if (s && a[15]) x = x - 65536;
            if (s && b[15]) y = y - 65536;
            prod = x * y;
            p    = prod[31:0];
            ovf  = s ? (prod < -32768 || prod > 32767) : (prod > 65535);
        end
    endfunction

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic bm, input bit scramble);
        exp_t e;
        int   edges;
        bit   done;
        model(a, b, s, bm, e.p, e.ovf);
        e.lat = bm ? 9 : 17;
        sb.push_back(e);
        ifc.a          = a;
        ifc.b          = b;
        ifc.signed_mul = s;
        ifc.byte_mode  = bm;
        @(posedge clk);
        #1 ifc.run_in = ~ifc.run_in;
        edges = 0;
        done  = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (ifc.run_out === ifc.run_in) begin
                done = 1'b1;
            end else if (scramble && edges <= 15) begin
                ifc.a          = 16'($urandom);
                ifc.b          = 16'($urandom);
                ifc.signed_mul = 1'($urandom);
            end
        end
        e = sb.pop_front();
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " latency"}, 64'(edges), 64'(e.lat));
        check({tag, " p"}, 64'(ifc.p), 64'(e.p));
        check({tag, " ovf"}, 64'(ifc.ovf), 64'(e.ovf));
    endtask

    logic [31:0] held_p;
    logic        held_run_out;

    initial begin
        reset          = 1'b1;
        ifc.run_in     = 1'b0;
        ifc.a          = 16'h0000;
        ifc.b          = 16'h0000;
        ifc.signed_mul = 1'b0;
        ifc.byte_mode  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset run_out", 64'(ifc.run_out), 64'd0);
        check("reset p", 64'(ifc.p), 64'd0);
        check("reset ovf", 64'(ifc.ovf), 64'd0);
        @(negedge clk) reset = 1'b0;

        run_op("u16 ffff*ffff", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_op("s16 -3*5", 16'hFFFD, 16'h0005, 1'b1, 1'b0, 1'b0);
        run_op("s16 8000*8000", 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0);
        run_op("u8 10*10", 16'h0010, 16'h0010, 1'b0, 1'b1, 1'b0);
        run_op("s8 80*02", 16'h0080, 16'h0002, 1'b1, 1'b1, 1'b0);
        run_op("s8 ff*02", 16'h00FF, 16'h0002, 1'b1, 1'b1, 1'b0);
        run_op("u16 zero", 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        run_op("s16 7fff*8000", 16'h7FFF, 16'h8000, 1'b1, 1'b0, 1'b0);
        run_op("s8 80*80", 16'h1280, 16'h3480, 1'b1, 1'b1, 1'b0);

        // operands wiggle while busy; result must follow the captured copies
        run_op("stable", 16'h9234, 16'h0567, 1'b1, 1'b0, 1'b1);
        held_p       = ifc.p;
        held_run_out = ifc.run_out;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            ifc.a = 16'($urandom);
            ifc.b = 16'($urandom);
            check("idle p hold", 64'(ifc.p), 64'(held_p));
            check("idle run_out hold", 64'(ifc.run_out), 64'(held_run_out));
        end

        // reset in the middle of an operation
        ifc.a          = 16'h00FF;
        ifc.b          = 16'h00FF;
        ifc.signed_mul = 1'b0;
        ifc.byte_mode  = 1'b0;
        @(posedge clk);
        #1 ifc.run_in = ~ifc.run_in;
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort run_out", 64'(ifc.run_out), 64'd0);
        check("abort p", 64'(ifc.p), 64'd0);
        check("abort ovf", 64'(ifc.ovf), 64'd0);
        ifc.run_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("post-reset no toggle", 64'(ifc.run_out), 64'd0);
        run_op("u16 3*7", 16'h0003, 16'h0007, 1'b0, 1'b0, 1'b0);

        // back-to-back requests
        run_op("b2b first", 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0);
        run_op("b2b second", 16'hFF00, 16'h0101, 1'b1, 1'b0, 1'b0);
        run_op("b2b third", 16'h00C3, 16'h007F, 1'b1, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("toggle balance", 64'(ifc.run_out), 64'(ifc.run_in));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
